// File: rtl/seq_right_shifter_32.sv
`default_nettype none
// ============================================================================
// Module   : seq_right_shifter_32
// Brief    : Multi-cycle 32-bit logical/arithmetic right shifter (IDLE/SHIFT/DONE).
//            Define SHIFT_2BIT_STEP_EN to shift two bit positions per SHIFT cycle.
// Revision : 1.0 - initial release
// ============================================================================
module seq_right_shifter_32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] in,
    input  logic [4:0]  shamt,
    input  logic        arith,
    output logic [31:0] out,
    output logic        busy,
    output logic        done
);

`ifdef SHIFT_2BIT_STEP_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] data_q;
    logic [4:0]  cnt_q;
    logic        fill_q;
    logic [31:0] out_q;
    logic        busy_q;
    logic        done_q;

    logic [4:0]  step;
    logic [31:0] data_d;
    logic [4:0]  cnt_d;

    // The step is clamped to the residue so the final odd position is handled
    // without letting cnt wrap.
    always_comb begin
        step   = (cnt_q >= 5'(STEP)) ? 5'(STEP) : cnt_q;
        data_d = data_q;
        case (step)
            5'd2:    data_d = {{2{fill_q}}, data_q[31:2]};
            5'd1:    data_d = {fill_q, data_q[31:1]};
            default: data_d = data_q;
        endcase
        cnt_d = cnt_q - step;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            data_q  <= 32'h0;
            cnt_q   <= 5'd0;
            fill_q  <= 1'b0;
            out_q   <= 32'h0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        data_q <= in;
                        cnt_q  <= shamt;
                        fill_q <= arith & in[31];
                        busy_q <= 1'b1;
                        if (shamt != 5'd0) begin
                            state_q <= S_SHIFT;
                            done_q  <= 1'b0;
                        end else begin
                            state_q <= S_DONE;
                            out_q   <= in;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    data_q <= data_d;
                    cnt_q  <= cnt_d;
                    if (cnt_d == 5'd0) begin
                        state_q <= S_DONE;
                        out_q   <= data_d;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_right_shifter_32.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_right_shifter_32
// Brief    : Self-checking bench for seq_right_shifter_32 against a shift model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_right_shifter_32;

`ifdef SHIFT_2BIT_STEP_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] op_in;
    logic [4:0]  op_shamt;
    logic        op_arith;
    logic [31:0] out;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    seq_right_shifter_32 dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .in    (op_in),
        .shamt (op_shamt),
        .arith (op_arith),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: extend to 64 bits with the fill word above, then shift once.
    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] sh,
                                              input logic ar);
        logic [63:0] ext;
        ext = {(ar && a[31]) ? 32'hFFFF_FFFF : 32'h0, a};
        ext = ext >> sh;
        return ext[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation and follow it to completion. repulse_at > 0 drives a
    // spurious start (with different operands) in that busy cycle.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [4:0] sh,
                          input logic ar, input int repulse_at);
        logic [31:0] exp_out;
        int          exp_lat;
        int          k;
        int          done_k;
        bit          got;
        bit          busy_bad;
        exp_out  = ref_shift(a, sh, ar);
        exp_lat  = (int'(sh) + STEP - 1) / STEP + 1;
        got      = 1'b0;
        busy_bad = 1'b0;
        done_k   = 0;
        k        = 1;
        @(negedge clk);
        start = 1'b1; op_in = a; op_shamt = sh; op_arith = ar;
        @(posedge clk);
        #1;
        start = 1'b0; op_in = $urandom; op_shamt = 5'($urandom); op_arith = 1'($urandom);
        while (k <= 40 && !got) begin
            @(negedge clk);
            if (done) begin
                got    = 1'b1;
                done_k = k;
            end else begin
                if (busy !== 1'b1) busy_bad = 1'b1;
                if (k == repulse_at) begin
                    start = 1'b1; op_in = 32'h1; op_shamt = 5'd1; op_arith = 1'b0;
                end
                @(posedge clk);
                #1;
                start = 1'b0;
                k++;
            end
        end
        chk({tag, " latency"}, 32'(done_k), 32'(exp_lat));
        chk({tag, " out"}, out, exp_out);
        chk({tag, " busy_at_done"}, {31'h0, busy}, 32'h1);
        chk({tag, " busy_while_shifting"}, {31'h0, busy_bad}, 32'h0);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, {31'h0, done}, 32'h0);
        chk({tag, " idle_after"}, {31'h0, busy}, 32'h0);
        chk({tag, " out_hold"}, out, exp_out);
    endtask

    initial begin
        int  stray;
        reset = 1'b1; start = 1'b1; op_in = 32'hDEAD_BEEF; op_shamt = 5'd3; op_arith = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset out", out, 32'h0);
        chk("reset busy", {31'h0, busy}, 32'h0);
        chk("reset done", {31'h0, done}, 32'h0);
        reset = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        chk("start_in_reset discarded", {31'h0, busy}, 32'h0);

        run_op("r028", 32'h0000_0004, 5'd2, 1'b0, 0);
        run_op("r029a", 32'h8000_0000, 5'd31, 1'b1, 0);
        run_op("r029l", 32'h8000_0000, 5'd31, 1'b0, 0);
        run_op("r030", 32'h1234_5678, 5'd0, 1'b0, 0);
        run_op("r031", 32'hF000_0000, 5'd3, 1'b1, 0);
        run_op("r032", 32'hFFFF_FFFF, 5'd8, 1'b0, 2);
        run_op("arith_pos", 32'h7000_0000, 5'd4, 1'b1, 0);

        // Reset in the middle of a long shift, with a coincident start.
        @(negedge clk);
        start = 1'b1; op_in = 32'hCAFE_F00D; op_shamt = 5'd20; op_arith = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("midreset busy", {31'h0, busy}, 32'h0);
        chk("midreset done", {31'h0, done}, 32'h0);
        chk("midreset out", out, 32'h0);
        stray = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        chk("midreset no_done", 32'(stray), 32'h0);
        run_op("after_reset", 32'hA5A5_0F0F, 5'd5, 1'b1, 0);

        for (int i = 0; i < 30; i++) begin
            run_op($sformatf("rand%0d", i), $urandom, 5'($urandom), 1'($urandom), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
